// File: rtl/audio_pkg.sv
// Shared definitions for the oscillator amplitude path: envelope state codes
// and envelope width constants.
package audio_pkg;

    localparam int ENV_WIDTH_DEF = 16;
    localparam logic [ENV_WIDTH_DEF-1:0] ENV_MAX = {ENV_WIDTH_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/envelope_scaler.sv
// Two-stage multiply pipeline: full-width product, then truncation to the
// top DATA_WIDTH bits with a one-cycle valid pulse.
module envelope_scaler #(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] wave_in,
    input  logic [ENV_WIDTH-1:0]  env_in,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  out_valid
);

    localparam int PW = DATA_WIDTH + ENV_WIDTH;

    logic [PW-1:0]         prod_q;
    logic                  prod_valid_q;
    logic [DATA_WIDTH-1:0] audio_q;
    logic                  out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            audio_q      <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            prod_valid_q <= valid_in;
            out_valid_q  <= prod_valid_q;
            if (valid_in) begin
                prod_q <= {{ENV_WIDTH{1'b0}}, wave_in} * {{DATA_WIDTH{1'b0}}, env_in};
            end
            // Truncating shift: keep only the top DATA_WIDTH product bits.
            if (prod_valid_q) begin
                audio_q <= prod_q[PW-1:ENV_WIDTH];
            end
        end
    end

    assign audio_out = audio_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// Gated ADSR envelope generator, advanced on sample_tick, feeding a scaler
// that multiplies the captured oscillator sample by the envelope.
module adsr_envelope
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = ENV_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  gate,
    input  logic [ENV_WIDTH-1:0]  attack_rate,
    input  logic [ENV_WIDTH-1:0]  decay_rate,
    input  logic [ENV_WIDTH-1:0]  sustain_level,
    input  logic [ENV_WIDTH-1:0]  release_rate,
    input  logic [DATA_WIDTH-1:0] wave_in,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  out_valid,
    output logic [ENV_WIDTH-1:0]  env_level,
    output logic [2:0]            env_state
);

    localparam logic [ENV_WIDTH:0] ENV_MAX_WIDE = {1'b0, {ENV_WIDTH{1'b1}}};

    env_state_t            state_q, state_d;
    logic [ENV_WIDTH-1:0]  env_q, env_d;
    logic [DATA_WIDTH-1:0] wave_q;
    logic                  tick_q;

    logic [ENV_WIDTH:0] attack_sum;
    logic [ENV_WIDTH:0] decay_floor;

    // Sums are one bit wider so saturation and the decay floor never wrap.
    assign attack_sum  = {1'b0, env_q} + {1'b0, attack_rate};
    assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
            wave_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            tick_q  <= sample_tick;
            if (sample_tick) begin
                wave_q <= wave_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (sample_tick) begin
            if (gate && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
                state_d = ST_ATTACK;
            end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                   state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                case (state_q)
                    ST_ATTACK: begin
                        if (attack_sum >= ENV_MAX_WIDE) begin
                            env_d   = {ENV_WIDTH{1'b1}};
                            state_d = ST_DECAY;
                        end else begin
                            env_d = attack_sum[ENV_WIDTH-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if ({1'b0, env_q} <= decay_floor) begin
                            env_d   = sustain_level;
                            state_d = ST_SUSTAIN;
                        end else begin
                            env_d = env_q - decay_rate;
                        end
                    end
                    ST_SUSTAIN: env_d = sustain_level;
                    ST_RELEASE: begin
                        if (env_q <= release_rate) begin
                            env_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            env_d = env_q - release_rate;
                        end
                    end
                    default: begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    envelope_scaler #(
        .DATA_WIDTH(DATA_WIDTH),
        .ENV_WIDTH (ENV_WIDTH)
    ) u_scaler (
        .clk      (clk),
        .rst      (rst),
        .valid_in (tick_q),
        .wave_in  (wave_q),
        .env_in   (env_q),
        .audio_out(audio_out),
        .out_valid(out_valid)
    );

    assign env_level = env_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed ADSR scenarios plus randomized ticks
// checked against an integer-arithmetic envelope model.
module tb_adsr_envelope;

    localparam int EMAX = 65535;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [15:0] sustain_level;
    logic [15:0] release_rate;
    logic [15:0] wave_in;
    logic [15:0] audio_out;
    logic        out_valid;
    logic [15:0] env_level;
    logic [2:0]  env_state;

    int total;
    int bad;
    int m_state;
    int m_env;

    adsr_envelope #(.DATA_WIDTH(16), .ENV_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .wave_in      (wave_in),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .env_level    (env_level),
        .env_state    (env_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Envelope reference: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    task automatic model_step(input logic g);
        int ar, dr, sl, rr;
        ar = int'(attack_rate);
        dr = int'(decay_rate);
        sl = int'(sustain_level);
        rr = int'(release_rate);
        if (g && (m_state == 0 || m_state == 4)) begin
            m_state = 1;
        end else if (!g && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (m_state == 0) begin
            m_env = 0;
        end else if (m_state == 1) begin
            if (m_env + ar >= EMAX) begin
                m_env = EMAX;
                m_state = 2;
            end else begin
                m_env = m_env + ar;
            end
        end else if (m_state == 2) begin
            if (m_env <= sl + dr) begin
                m_env = sl;
                m_state = 3;
            end else begin
                m_env = m_env - dr;
            end
        end else if (m_state == 3) begin
            m_env = sl;
        end else begin
            if (m_env <= rr) begin
                m_env = 0;
                m_state = 0;
            end else begin
                m_env = m_env - rr;
            end
        end
    endtask

    // One tick, four clocks long; checks envelope and the output pulse timing.
    task automatic drive_tick(input logic g, input logic [15:0] w);
        int exp_audio;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL tick_pre_valid: got %0b want 0", out_valid);
        end
        gate = g;
        wave_in = w;
        sample_tick = 1'b1;
        model_step(g);
        exp_audio = int'((longint'(w) * longint'(m_env)) >> 16);
        @(negedge clk);
        sample_tick = 1'b0;
        total++;
        if (env_level !== 16'(m_env) || env_state !== 3'(m_state)) begin
            bad++;
            $display("FAIL tick_env: got env=%0d st=%0d want env=%0d st=%0d",
                     env_level, env_state, m_env, m_state);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_t0: got %0b want 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_t1: got %0b want 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || audio_out !== 16'(exp_audio)) begin
            bad++;
            $display("FAIL valid_t2: got v=%0b audio=%0d want v=1 audio=%0d",
                     out_valid, audio_out, exp_audio);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_state = 0;
        m_env = 0;
    endtask

    task automatic check_env(input string name, input int exp_env, input int exp_st);
        total++;
        if (env_level !== 16'(exp_env) || env_state !== 3'(exp_st)) begin
            bad++;
            $display("FAIL %s: got env=%0d st=%0d want env=%0d st=%0d",
                     name, env_level, env_state, exp_env, exp_st);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (env_state !== 3'd0 || env_level !== 16'd0 || audio_out !== 16'd0 ||
            out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d env=%0d audio=%0d v=%0b want 0 0 0 0",
                     env_state, env_level, audio_out, out_valid);
        end
    endtask

    task automatic test_attack();
        attack_rate = 16'd16384;
        drive_tick(1'b1, 16'h1234);
        check_env("attack_first", 0, 1);
        drive_tick(1'b1, 16'h4000);
        check_env("attack_1", 16384, 1);
        drive_tick(1'b1, 16'h8000);
        check_env("attack_2", 32768, 1);
        drive_tick(1'b1, 16'hFFFF);
        check_env("attack_3", 49152, 1);
        drive_tick(1'b1, 16'hABCD);
        check_env("attack_sat", 65535, 2);
    endtask

    task automatic test_decay_sustain();
        decay_rate = 16'd8192;
        sustain_level = 16'd40000;
        drive_tick(1'b1, 16'h7777);
        check_env("decay_1", 57343, 2);
        drive_tick(1'b1, 16'h2222);
        check_env("decay_2", 49151, 2);
        for (int i = 0; i < 6 && m_state == 2; i++) begin
            drive_tick(1'b1, 16'($urandom_range(0, 65535)));
        end
        check_env("sustain_reached", 40000, 3);
        sustain_level = 16'd30000;
        drive_tick(1'b1, 16'h5555);
        check_env("sustain_track", 30000, 3);
    endtask

    task automatic test_release_retrigger();
        release_rate = 16'd20000;
        drive_tick(1'b0, 16'h1111);
        check_env("release_enter", 30000, 4);
        drive_tick(1'b0, 16'h9999);
        check_env("release_step", 10000, 4);
        drive_tick(1'b1, 16'hC000);
        check_env("retrigger", 10000, 1);
        drive_tick(1'b1, 16'h0FFF);
        check_env("retrigger_step", 26384, 1);
        drive_tick(1'b0, 16'h0001);
        release_rate = 16'd30000;
        drive_tick(1'b0, 16'h0002);
        check_env("release_idle", 0, 0);
    endtask

    task automatic test_no_tick();
        int env_before;
        int st_before;
        env_before = m_env;
        st_before = m_state;
        @(negedge clk);
        gate = ~gate;
        repeat (6) @(negedge clk);
        check_env("hold_no_tick", env_before, st_before);
    endtask

    task automatic test_scaling();
        apply_reset();
        attack_rate = 16'd32768;
        drive_tick(1'b1, 16'hFFFF);
        drive_tick(1'b1, 16'hFFFF);
        check_env("scale_env", 32768, 1);
        total++;
        if (audio_out !== 16'd32767) begin
            bad++;
            $display("FAIL scale_audio: got %0d want 32767", audio_out);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL scale_pulse_width: got %0b want 0", out_valid);
        end
    endtask

    function automatic logic [15:0] pick_rate();
        case ($urandom_range(0, 4))
            0: return 16'd0;
            1: return 16'($urandom_range(1, 2000));
            2: return 16'hFFFF;
            default: return 16'($urandom_range(1, 65535));
        endcase
    endfunction

    task automatic test_random();
        logic g;
        g = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) g = ~g;
            if ($urandom_range(0, 7) == 0) begin
                attack_rate = pick_rate();
                decay_rate = pick_rate();
                release_rate = pick_rate();
            end
            if ($urandom_range(0, 3) == 0) sustain_level = pick_rate();
            drive_tick(g, 16'($urandom_range(0, 65535)));
        end
    endtask

    task automatic test_reset_mid_attack();
        int stale;
        apply_reset();
        attack_rate = 16'd1000;
        drive_tick(1'b1, 16'hFFFF);
        drive_tick(1'b1, 16'hFFFF);
        drive_tick(1'b1, 16'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        sample_tick = 1'b1;
        gate = 1'b1;
        wave_in = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0;
        sample_tick = 1'b0;
        m_state = 0;
        m_env = 0;
        total++;
        if (env_state !== 3'd0 || env_level !== 16'd0 || audio_out !== 16'd0 ||
            out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got st=%0d env=%0d audio=%0d v=%0b want 0 0 0 0",
                     env_state, env_level, audio_out, out_valid);
        end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL reset_stale_valid: got %0d pulses want 0", stale);
        end
        check_env("reset_hold", 0, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_state = 0;
        m_env = 0;
        rst = 1'b1;
        sample_tick = 1'b0;
        gate = 1'b0;
        attack_rate = '0;
        decay_rate = '0;
        sustain_level = '0;
        release_rate = '0;
        wave_in = '0;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_no_tick();
        test_release_retrigger();
        test_scaling();
        test_reset_mid_attack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
